exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Exception/interrupt sequencer for the MEM stage; drives the CP0 register file's exception inputs.
//  - Prioritises exception flags and pending interrupts.
//  - Waits for any outstanding data-SRAM transaction to drain.
//  - Issues a one-cycle exception commit to CP0 and flushes the pipeline.
//  - Hands the redirect PC (exception vector, or EPC for ERET) to fetch with a valid/ready handshake.
// PARAMETERS
//  EXC_VECTOR   32'hBFC0_0380   redirect target for every exception except ERET
// PORTS
//  clk                 in   1   clock; all state updates on posedge
//  rst                 in   1   reset, asynchronous, active-high
//  mem_valid_i         in   1   MEM-stage instruction is valid
//  mem_pc_i            in   32  PC of MEM-stage instruction
//  mem_in_delayslot_i  in   1   MEM-stage instruction sits in a branch delay slot
//  mem_addr_i          in   32  data address of MEM-stage load/store
//  mem_exc_i           in   8   flags: [0]AdEL-fetch [1]RI [2]Ov [3]Sys [4]Bp [5]AdEL-load [6]AdES-store [7]ERET
//  cp0_status_i        in   32  CP0 Status (IE=bit0, EXL=bit1, IM=[15:8])
//  cp0_cause_i         in   32  CP0 Cause (IP=[15:8])
//  cp0_epc_i           in   32  CP0 EPC
//  mem_busy_i          in   1   data-SRAM transaction outstanding
//  newpc_ready_i       in   1   fetch accepts redirect PC
//  excepttype_o        out  32  exception code to CP0; nonzero for exactly one cycle per event
//  exc_pc_o            out  32  faulting PC to CP0 (current_inst_addr)
//  exc_delayslot_o     out  1   delay-slot flag to CP0
//  bad_addr_o          out  32  BadVAddr value to CP0
//  flush_o             out  1   flush IF..MEM pipeline registers
//  busy_o              out  1   freeze the pipeline; high in every non-IDLE state
//  newpc_o             out  32  redirect target
//  newpc_valid_o       out  1   redirect target valid
// BEHAVIOUR
//  Reset: state=IDLE; every output 0. Asserting rst mid-sequence aborts: IDLE, no commit, no redirect.
//  Interrupt pending: int_pend = IE & ~EXL & |(cause[15:8] & status[15:8]).
//  - Only taken when mem_valid_i=1.
//  Priority, highest first (excepttype codes):
//  - interrupt 32'h1
//  - AdEL-fetch 32'h4
//  - RI 32'hA
//  - Ov 32'hC
//  - Sys 32'h8
//  - Bp 32'h9
//  - AdEL-load 32'h4
//  - AdES-store 32'h5
//  - ERET 32'hE
//  Event detection:
//  - Event = mem_valid_i & (int_pend | |mem_exc_i). mem_valid_i=0 means no event.
//  - Inputs are sampled only in IDLE; pipeline is frozen by busy_o otherwise.
//  Captured on detection:
//  - code, mem_pc_i, mem_in_delayslot_i.
//  - bad address = mem_pc_i for AdEL-fetch; mem_addr_i for AdEL-load/AdES-store; else 0.
//  FSM:
//  - IDLE: on event, go to DRAIN if mem_busy_i=1, else COMMIT. busy_o asserts the cycle after detection.
//  - DRAIN: hold until mem_busy_i=0, then COMMIT. No timeout.
//  - COMMIT (1 cycle): excepttype_o=code; exc_pc_o, exc_delayslot_o and bad_addr_o valid; flush_o=1.
//    newpc_o = cp0_epc_i sampled in this cycle if code=E, else EXC_VECTOR. Go to REDIRECT.
//  - REDIRECT: flush_o=1, newpc_valid_o=1, newpc_o stable; excepttype_o=0.
//    Leave to IDLE on newpc_ready_i=1; stall indefinitely otherwise.
//  Latency, event to newpc_valid_o with no drain and ready held high:
//  - Detect at cycle N, COMMIT at N+1, REDIRECT at N+2, IDLE at N+3.
//  Outputs:
//  - All outputs are registered.
//  - excepttype_o, bad_addr_o, exc_pc_o and exc_delayslot_o are 0 outside COMMIT.
//  - No timer logic; timer interrupts arrive via cause IP bits.
// STRUCTURE
//  Shared defines (defines.vh): EXC_* excepttype codes, EXC_VECTOR default, FSM state encoding (2 bits).
//  Sub-module exc_prio_enc (combinational): mem_exc_i + int_pend -> {hit, code, bad_addr_sel}.
//  Top module holds the FSM and capture registers.
// TESTING
//  Sys at PC 0xBFC0_0100, not in delay slot, busy=0, ready=1:
//  - excepttype=0x8 and exc_pc=0xBFC0_0100 at N+1; newpc=0xBFC0_0380 valid at N+2.
//  Ov and Sys both set, in delay slot, PC 0x80:
//  - code 0xC, exc_delayslot=1, exc_pc=0x80.
//  IE=1, EXL=0, IM[2]=1, IP[2]=1, RI also flagged:
//  - code 0x1. Same with EXL=1 -> code 0xA.
//  AdES at addr 0x1001 with mem_busy_i high for 3 cycles:
//  - DRAIN 3 cycles, then excepttype=0x5, bad_addr=0x1001.
//  ERET with cp0_epc_i=0xBFC0_0200, newpc_ready_i low for 2 cycles:
//  - code 0xE; newpc=0xBFC0_0200 held valid until ready; flush_o high throughout.
//  rst pulsed during DRAIN:
//  - All outputs 0 immediately; no commit pulse after release.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception sequencer: excepttype codes,
// flag bit positions, FSM state encoding and bad-address source selector.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'hA;
    localparam logic [31:0] EXC_OV   = 32'hC;
    localparam logic [31:0] EXC_ERET = 32'hE;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Bit positions inside mem_exc_i
    localparam int F_ADEL_FETCH = 0;
    localparam int F_RI         = 1;
    localparam int F_OV         = 2;
    localparam int F_SYS        = 3;
    localparam int F_BP         = 4;
    localparam int F_ADEL_LOAD  = 5;
    localparam int F_ADES_STORE = 6;
    localparam int F_ERET       = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        BAD_NONE = 2'd0,
        BAD_PC   = 2'd1,
        BAD_ADDR = 2'd2
    } bad_sel_t;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational priority encoder: picks the highest-priority pending cause and
// reports which source feeds BadVAddr.
module exc_ctrl_prio
    import exc_ctrl_pkg::*;
(
    input  logic [7:0]  exc,
    input  logic        int_pend,
    output logic        hit,
    output logic [31:0] code,
    output bad_sel_t    bad_sel
);

    always_comb begin
        hit     = 1'b1;
        code    = EXC_NONE;
        bad_sel = BAD_NONE;
        if (int_pend) begin
            code = EXC_INT;
        end else if (exc[F_ADEL_FETCH]) begin
            code    = EXC_ADEL;
            bad_sel = BAD_PC;
        end else if (exc[F_RI]) begin
            code = EXC_RI;
        end else if (exc[F_OV]) begin
            code = EXC_OV;
        end else if (exc[F_SYS]) begin
            code = EXC_SYS;
        end else if (exc[F_BP]) begin
            code = EXC_BP;
        end else if (exc[F_ADEL_LOAD]) begin
            code    = EXC_ADEL;
            bad_sel = BAD_ADDR;
        end else if (exc[F_ADES_STORE]) begin
            code    = EXC_ADES;
            bad_sel = BAD_ADDR;
        end else if (exc[F_ERET]) begin
            code = EXC_ERET;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer for the MEM stage: detects, drains outstanding
// data-SRAM traffic, pulses a one-cycle CP0 commit and hands the redirect PC to fetch.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0]  mem_exc_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        mem_busy_i,
    input  logic        newpc_ready_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic [31:0] newpc_o,
    output logic        newpc_valid_o
);

    state_t      state_reg, state_next;

    logic        int_pend;
    logic        enc_hit;
    logic [31:0] enc_code;
    bad_sel_t    enc_sel;
    logic        event_hit;
    logic [31:0] enc_bad;

    logic [31:0] code_reg, code_next;
    logic [31:0] pc_reg, pc_next;
    logic        ds_reg, ds_next;
    logic [31:0] bad_reg, bad_next;

    logic [31:0] excepttype_reg, excepttype_next;
    logic [31:0] exc_pc_reg, exc_pc_next;
    logic        exc_ds_reg, exc_ds_next;
    logic [31:0] bad_addr_reg, bad_addr_next;
    logic        flush_reg, flush_next;
    logic        busy_reg, busy_next;
    logic [31:0] newpc_reg, newpc_next;
    logic        newpc_valid_reg, newpc_valid_next;

    // Only IE, EXL and the IM/IP bytes matter here.
    logic        unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                               cp0_cause_i[31:16], cp0_cause_i[7:0]};

    assign int_pend  = cp0_status_i[0] & ~cp0_status_i[1]
                     & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
    assign event_hit = mem_valid_i & enc_hit;

    exc_ctrl_prio u_prio (
        .exc      (mem_exc_i),
        .int_pend (int_pend),
        .hit      (enc_hit),
        .code     (enc_code),
        .bad_sel  (enc_sel)
    );

    always_comb begin
        enc_bad = 32'h0;
        case (enc_sel)
            BAD_PC:   enc_bad = mem_pc_i;
            BAD_ADDR: enc_bad = mem_addr_i;
            default:  enc_bad = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, capture, and next values for the registered outputs.
    always_comb begin
        state_next       = state_reg;
        code_next        = code_reg;
        pc_next          = pc_reg;
        ds_next          = ds_reg;
        bad_next         = bad_reg;
        excepttype_next  = 32'h0;
        exc_pc_next      = 32'h0;
        exc_ds_next      = 1'b0;
        bad_addr_next    = 32'h0;
        flush_next       = 1'b0;
        newpc_next       = 32'h0;
        newpc_valid_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (event_hit) begin
                    code_next  = enc_code;
                    pc_next    = mem_pc_i;
                    ds_next    = mem_in_delayslot_i;
                    bad_next   = enc_bad;
                    state_next = mem_busy_i ? ST_DRAIN : ST_COMMIT;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy_i) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (newpc_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);

        if (state_next == ST_COMMIT) begin
            excepttype_next = code_next;
            exc_pc_next     = pc_next;
            exc_ds_next     = ds_next;
            bad_addr_next   = bad_next;
            flush_next      = 1'b1;
        end

        if (state_next == ST_REDIRECT) begin
            flush_next       = 1'b1;
            newpc_valid_next = 1'b1;
            // EPC is sampled during the COMMIT cycle, then held while fetch stalls.
            if (state_reg == ST_COMMIT) begin
                newpc_next = (code_reg == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else begin
                newpc_next = newpc_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_reg        <= 32'h0;
            pc_reg          <= 32'h0;
            ds_reg          <= 1'b0;
            bad_reg         <= 32'h0;
            excepttype_reg  <= 32'h0;
            exc_pc_reg      <= 32'h0;
            exc_ds_reg      <= 1'b0;
            bad_addr_reg    <= 32'h0;
            flush_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            newpc_reg       <= 32'h0;
            newpc_valid_reg <= 1'b0;
        end else begin
            code_reg        <= code_next;
            pc_reg          <= pc_next;
            ds_reg          <= ds_next;
            bad_reg         <= bad_next;
            excepttype_reg  <= excepttype_next;
            exc_pc_reg      <= exc_pc_next;
            exc_ds_reg      <= exc_ds_next;
            bad_addr_reg    <= bad_addr_next;
            flush_reg       <= flush_next;
            busy_reg        <= busy_next;
            newpc_reg       <= newpc_next;
            newpc_valid_reg <= newpc_valid_next;
        end
    end

    assign excepttype_o    = excepttype_reg;
    assign exc_pc_o        = exc_pc_reg;
    assign exc_delayslot_o = exc_ds_reg;
    assign bad_addr_o      = bad_addr_reg;
    assign flush_o         = flush_reg;
    assign busy_o          = busy_reg;
    assign newpc_o         = newpc_reg;
    assign newpc_valid_o   = newpc_valid_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed scoreboard bench for exc_ctrl: stimulus pushes expected commits and
// redirects; a monitor pops and compares whenever the DUT presents them.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = 32'h0;
    logic        mem_ds = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [7:0]  mem_exc = 8'h0;
    logic [31:0] status = 32'h0;
    logic [31:0] cause = 32'h0;
    logic [31:0] epc = 32'h0;
    logic        mem_busy = 1'b0;
    logic        newpc_ready = 1'b1;

    logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, newpc_o;
    logic        exc_delayslot_o, flush_o, busy_o, newpc_valid_o;

    exc_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .mem_valid_i        (mem_valid),
        .mem_pc_i           (mem_pc),
        .mem_in_delayslot_i (mem_ds),
        .mem_addr_i         (mem_addr),
        .mem_exc_i          (mem_exc),
        .cp0_status_i       (status),
        .cp0_cause_i        (cause),
        .cp0_epc_i          (epc),
        .mem_busy_i         (mem_busy),
        .newpc_ready_i      (newpc_ready),
        .excepttype_o       (excepttype_o),
        .exc_pc_o           (exc_pc_o),
        .exc_delayslot_o    (exc_delayslot_o),
        .bad_addr_o         (bad_addr_o),
        .flush_o            (flush_o),
        .busy_o             (busy_o),
        .newpc_o            (newpc_o),
        .newpc_valid_o      (newpc_valid_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        ds;
        string       name;
    } commit_t;

    commit_t     commit_q[$];
    logic [31:0] redir_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge, after stimulus has settled.
    initial begin
        commit_t     e;
        logic [31:0] np;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && excepttype_o != 32'h0) begin
                if (commit_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_commit actual=%h required=none", excepttype_o);
                end else begin
                    e = commit_q.pop_front();
                    chk({e.name, "_code"}, excepttype_o, e.code);
                    chk({e.name, "_exc_pc"}, exc_pc_o, e.pc);
                    chk({e.name, "_delayslot"}, {31'h0, exc_delayslot_o}, {31'h0, e.ds});
                    chk({e.name, "_bad_addr"}, bad_addr_o, e.bad);
                    chk({e.name, "_commit_flush"}, {31'h0, flush_o}, 32'h1);
                    chk({e.name, "_commit_busy"}, {31'h0, busy_o}, 32'h1);
                end
            end
            if (!rst && newpc_valid_o && newpc_ready) begin
                if (redir_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_redirect actual=%h required=none", newpc_o);
                end else begin
                    np = redir_q.pop_front();
                    chk("redirect_newpc", newpc_o, np);
                    chk("redirect_excepttype_zero", excepttype_o, 32'h0);
                end
            end
        end
    end

    // Issue one event at the current falling edge and follow it to the handshake.
    task automatic run_evt(input string name, input logic [7:0] exc, input logic [31:0] pc,
                           input logic [31:0] addr, input logic ds, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep, input int busy_cyc,
                           input int ready_dly, input logic [31:0] exp_code,
                           input logic [31:0] exp_bad, input logic [31:0] exp_newpc);
        int commit_at;
        int valid_at;
        int valid_len;
        commit_q.push_back('{exp_code, pc, exp_bad, ds, name});
        redir_q.push_back(exp_newpc);
        mem_valid   = 1'b1;
        mem_exc     = exc;
        mem_pc      = pc;
        mem_addr    = addr;
        mem_ds      = ds;
        status      = st;
        cause       = ca;
        epc         = ep;
        mem_busy    = (busy_cyc > 0);
        newpc_ready = (ready_dly == 0);
        commit_at = 0;
        valid_at  = 0;
        valid_len = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            mem_valid = 1'b0;
            mem_exc   = 8'h0;
            mem_busy  = (k < busy_cyc);
            if (excepttype_o != 32'h0 && commit_at == 0) commit_at = k;
            if (newpc_valid_o) begin
                if (valid_at == 0) valid_at = k;
                valid_len++;
                chk({name, "_redirect_flush"}, {31'h0, flush_o}, 32'h1);
                newpc_ready = ((k - valid_at) >= ready_dly);
            end else if (valid_at != 0) begin
                break;
            end else if (commit_at == 0) begin
                chk({name, "_pre_commit_excepttype"}, excepttype_o, 32'h0);
            end
        end
        chk({name, "_commit_latency"}, commit_at, 1 + busy_cyc);
        chk({name, "_redirect_latency"}, valid_at, 2 + busy_cyc);
        chk({name, "_redirect_length"}, valid_len, ready_dly + 1);
        chk({name, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
        chk({name, "_idle_flush"}, {31'h0, flush_o}, 32'h0);
        $display("txn %s: code=%h commit@%0d redirect@%0d cycles=%0d", name, exp_code,
                 commit_at, valid_at, valid_len);
        status      = 32'h0;
        cause       = 32'h0;
        newpc_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_excepttype", excepttype_o, 32'h0);
        chk("reset_exc_pc", exc_pc_o, 32'h0);
        chk("reset_bad_addr", bad_addr_o, 32'h0);
        chk("reset_newpc", newpc_o, 32'h0);
        chk("reset_flags", {26'h0, exc_delayslot_o, flush_o, busy_o, newpc_valid_o, 2'b0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // name, exc, pc, addr, ds, status, cause, epc, busy, ready_dly, code, bad, newpc
        run_evt("sys", 8'h08, 32'hBFC0_0100, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0,
                32'h8, 32'h0, 32'hBFC0_0380);
        run_evt("ov_over_sys", 8'h0C, 32'h0000_0080, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 0, 0,
                32'hC, 32'h0, 32'hBFC0_0380);
        run_evt("int_over_ri", 8'h02, 32'h8000_1000, 32'h0, 1'b0, 32'h0000_0401, 32'h0000_0400,
                32'h0, 0, 0, 32'h1, 32'h0, 32'hBFC0_0380);
        run_evt("ri_exl_masks_int", 8'h02, 32'h8000_1004, 32'h0, 1'b0, 32'h0000_0403,
                32'h0000_0400, 32'h0, 0, 0, 32'hA, 32'h0, 32'hBFC0_0380);
        run_evt("ades_drain", 8'h40, 32'h8000_2000, 32'h0000_1001, 1'b0, 32'h0, 32'h0, 32'h0,
                3, 0, 32'h5, 32'h0000_1001, 32'hBFC0_0380);
        run_evt("eret_stall", 8'h80, 32'h8000_3000, 32'h0, 1'b0, 32'h0, 32'h0, 32'hBFC0_0200,
                0, 2, 32'hE, 32'h0, 32'hBFC0_0200);
        run_evt("adel_fetch", 8'h01, 32'hBFC0_0123, 32'h0000_7777, 1'b0, 32'h0, 32'h0, 32'h0,
                0, 0, 32'h4, 32'hBFC0_0123, 32'hBFC0_0380);
        run_evt("adel_load", 8'h20, 32'h8000_4000, 32'h0000_2002, 1'b1, 32'h0, 32'h0, 32'h0,
                1, 0, 32'h4, 32'h0000_2002, 32'hBFC0_0380);
        run_evt("bp_over_adel_load", 8'h30, 32'h8000_5000, 32'h0000_3003, 1'b0, 32'h0, 32'h0,
                32'h0, 0, 1, 32'h9, 32'h0, 32'hBFC0_0380);

        // Flags and a pending interrupt without mem_valid must be ignored.
        mem_valid = 1'b0;
        mem_exc   = 8'h08;
        status    = 32'h0000_0401;
        cause     = 32'h0000_0400;
        repeat (4) @(negedge clk);
        chk("no_valid_busy", {31'h0, busy_o}, 32'h0);
        chk("no_valid_newpc_valid", {31'h0, newpc_valid_o}, 32'h0);
        mem_exc = 8'h0;
        status  = 32'h0;
        cause   = 32'h0;

        // Reset asserted while draining aborts the sequence.
        mem_valid = 1'b1;
        mem_exc   = 8'h08;
        mem_pc    = 32'h8000_6000;
        mem_busy  = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_exc   = 8'h0;
        @(negedge clk);
        chk("drain_busy", {31'h0, busy_o}, 32'h1);
        chk("drain_no_commit", excepttype_o, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy_o}, 32'h0);
        chk("abort_flush", {31'h0, flush_o}, 32'h0);
        chk("abort_newpc_valid", {31'h0, newpc_valid_o}, 32'h0);
        chk("abort_excepttype", excepttype_o, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        mem_busy = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_stays_idle", {31'h0, busy_o}, 32'h0);
        chk("abort_no_redirect", {31'h0, newpc_valid_o}, 32'h0);
        $display("txn rst_abort: busy=%0d newpc_valid=%0d", busy_o, newpc_valid_o);

        @(negedge clk);
        chk("scoreboard_drained", commit_q.size() + redir_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
